// File: rtl/err_metric_if.sv
// Sample/result bundle shared by err_metric_monitor and whatever drives it.
interface err_metric_if #(
    parameter int unsigned N            = 16,
    parameter int unsigned LOG2_SAMPLES = 10,
    parameter int unsigned FRAC         = 16
);
    logic                               start;
    logic                               in_valid;
    logic                               in_ready;
    logic [N-1:0]                       approx_sum;
    logic [N-1:0]                       exact_sum;
    logic                               busy;
    logic                               done;
    logic [LOG2_SAMPLES:0]              err_count;
    logic [N+LOG2_SAMPLES-1:0]          sum_ed;
    logic [N-1:0]                       max_ed;
    logic [N+7:0]                       med_fx;
    logic [LOG2_SAMPLES:0]              zero_count;
    logic [N+FRAC+LOG2_SAMPLES-1:0]     sum_rel;

    modport master (
        output start, in_valid, approx_sum, exact_sum,
        input  in_ready, busy, done, err_count, sum_ed, max_ed, med_fx, zero_count, sum_rel
    );

    modport slave (
        input  start, in_valid, approx_sum, exact_sum,
        output in_ready, busy, done, err_count, sum_ed, max_ed, med_fx, zero_count, sum_rel
    );
endinterface

// File: rtl/err_metric_monitor.sv
// Streaming error-statistics engine (ER, MED, max ED) over a 2^LOG2_SAMPLES window.
// Define ERR_METRIC_MRED_EN to add the restoring divider, zero_count and sum_rel (MRED).
module err_metric_monitor #(
    parameter int unsigned N            = 16,
    parameter int unsigned LOG2_SAMPLES = 10,
    parameter int unsigned FRAC         = 16
) (
    input  logic        clk,
    input  logic        rst,
    err_metric_if.slave bus
);
    localparam int unsigned CW = LOG2_SAMPLES + 1;
    localparam int unsigned SW = N + LOG2_SAMPLES;
    localparam int unsigned MW = N + 8;
    localparam int unsigned RW = N + FRAC + LOG2_SAMPLES;
    localparam logic [CW-1:0] FULL = {1'b1, {LOG2_SAMPLES{1'b0}}};

`ifdef ERR_METRIC_MRED_EN
    localparam int unsigned QW  = N + FRAC;
    localparam int unsigned DCW = $clog2(QW);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DIV = 2'd2, DONE = 2'd3} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd3} state_e;
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   err_count_q, err_count_d;
    logic [SW-1:0]   sum_ed_q, sum_ed_d;
    logic [N-1:0]    max_ed_q, max_ed_d;
    logic [N-1:0]    ed;
    logic            hs;

`ifdef ERR_METRIC_MRED_EN
    logic [CW-1:0]   zero_count_q, zero_count_d;
    logic [RW-1:0]   sum_rel_q, sum_rel_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic [DCW-1:0]  dcnt_q, dcnt_d;
    logic [N:0]      rem_sh, rem_nx;
    logic            ge;

    // One restoring step: dividend bits shift out of quo_q's MSB, quotient bits shift in.
    always_comb begin
        rem_sh = {rem_q, quo_q[QW-1]};
        ge     = (rem_sh >= {1'b0, dvs_q});
        rem_nx = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    end
`endif

    always_comb begin
        ed = (bus.approx_sum >= bus.exact_sum) ? (bus.approx_sum - bus.exact_sum)
                                               : (bus.exact_sum - bus.approx_sum);
        hs = bus.in_valid && (state_q == RUN);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_count_d = err_count_q;
        sum_ed_d    = sum_ed_q;
        max_ed_d    = max_ed_q;
`ifdef ERR_METRIC_MRED_EN
        zero_count_d = zero_count_q;
        sum_rel_d    = sum_rel_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        dcnt_d       = dcnt_q;
`endif
        case (state_q)
            RUN: begin
                if (hs) begin
                    cnt_d    = cnt_q + CW'(1);
                    sum_ed_d = sum_ed_q + SW'(ed);
                    if (ed != '0)      err_count_d = err_count_q + CW'(1);
                    if (ed > max_ed_q) max_ed_d    = ed;
                    if (cnt_d == FULL) state_d = DONE;
                    else               state_d = RUN;
`ifdef ERR_METRIC_MRED_EN
                    if (bus.exact_sum == '0) begin
                        zero_count_d = zero_count_q + CW'(1);
                    end else if (ed != '0) begin
                        state_d = DIV;
                        rem_d   = '0;
                        quo_d   = QW'(ed) << FRAC;
                        dvs_d   = bus.exact_sum;
                        dcnt_d  = '0;
                    end
`endif
                end
            end
`ifdef ERR_METRIC_MRED_EN
            DIV: begin
                rem_d  = N'(rem_nx);
                quo_d  = {quo_q[QW-2:0], ge};
                dcnt_d = dcnt_q + DCW'(1);
                if (dcnt_q == DCW'(QW - 1)) begin
                    sum_rel_d = sum_rel_q + RW'(quo_d);
                    if (cnt_q == FULL) state_d = DONE;
                    else               state_d = RUN;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // start wins over everything, including a same-cycle handshake or a running division
        if (bus.start) begin
            state_d     = RUN;
            cnt_d       = '0;
            err_count_d = '0;
            sum_ed_d    = '0;
            max_ed_d    = '0;
`ifdef ERR_METRIC_MRED_EN
            zero_count_d = '0;
            sum_rel_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_count_q <= '0;
            sum_ed_q    <= '0;
            max_ed_q    <= '0;
`ifdef ERR_METRIC_MRED_EN
            zero_count_q <= '0;
            sum_rel_q    <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            dcnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_count_q <= err_count_d;
            sum_ed_q    <= sum_ed_d;
            max_ed_q    <= max_ed_d;
`ifdef ERR_METRIC_MRED_EN
            zero_count_q <= zero_count_d;
            sum_rel_q    <= sum_rel_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvs_q        <= dvs_d;
            dcnt_q       <= dcnt_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.err_count = err_count_q;
    assign bus.sum_ed    = sum_ed_q;
    assign bus.max_ed    = max_ed_q;
    assign bus.med_fx    = MW'({sum_ed_q, 8'b0} >> LOG2_SAMPLES);
`ifdef ERR_METRIC_MRED_EN
    assign bus.busy       = (state_q == RUN) || (state_q == DIV);
    assign bus.zero_count = zero_count_q;
    assign bus.sum_rel    = sum_rel_q;
`else
    assign bus.busy       = (state_q == RUN);
    assign bus.zero_count = '0;
    assign bus.sum_rel    = RW'(0);
`endif
endmodule

// File: doc/err_metric_monitor.md
# err_metric_monitor

Synthesizable streaming error-statistics engine for approximate-adder evaluation. It takes pairs of approximate and exact N-bit sums over a window of 2^LOG2_SAMPLES samples and accumulates the error metrics:
- error count (ER numerator)
- summed and maximum error distance (MED, NMED)
- optionally, summed relative error (MRED)

It sits beside any N-bit approximate adder in on-chip/FPGA characterisation harnesses, so software can replace the long simulation-only metric loops.

## Interface
- N, 16, operand/sum width
- LOG2_SAMPLES, 10, window = 2^LOG2_SAMPLES samples (≥1)
- FRAC, 16, fractional bits of each relative-error quotient (MRED build only)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin (or restart) a window
- in_valid  in  1  sample present
- in_ready  out  1  sample accepted when in_valid & in_ready
- approx_sum  in  N  approximate adder output
- exact_sum  in  N  exact sum (mod 2^N)
- busy  out  1  window in progress
- done  out  1  one-cycle pulse, results final
- err_count  out  LOG2_SAMPLES+1  samples with approx_sum != exact_sum
- sum_ed  out  N+LOG2_SAMPLES  Σ|approx−exact|
- max_ed  out  N  max |approx−exact|
- med_fx  out  N+8  mean error distance, 8 fractional bits = ({sum_ed,8'b0}) >> LOG2_SAMPLES
- zero_count  out  LOG2_SAMPLES+1  samples with exact_sum == 0 (MRED build only)
- sum_rel  out  N+FRAC+LOG2_SAMPLES  Σ floor(ED·2^FRAC / exact_sum) (MRED build only)

## Operation
- States:
  - IDLE: in_ready=0.
  - RUN: in_ready=1.
  - DIV: MRED only; in_ready=0.
  - DONE: a single cycle; done=1.
- busy=1 in RUN and DIV.
- IDLE→RUN on start. On entry, clear these to 0: sample counter, err_count, sum_ed, max_ed, zero_count, sum_rel.
- start in RUN, DIV or DONE has the same effect as in IDLE: it aborts, clears, and enters RUN. An in-progress division is discarded. start has priority over a same-cycle handshake, and that sample is dropped.
- Per handshake in RUN:
  - ED = |approx_sum − exact_sum|, computed unsigned in N bits with no wrap. For example, approx 0x0000 / exact 0xFFFF gives ED=0xFFFF.
  - err_count += (ED≠0).
  - sum_ed += ED.
  - max_ed = max(max_ed, ED).
  - sample counter += 1.
- Accumulator widths are sized so that no overflow is possible in a full window.
- When the counter reaches 2^LOG2_SAMPLES, go to DONE (or first to DIV, if a division is pending). From DONE, go to IDLE.
- Results hold from DONE until the next start or rst.
- med_fx is combinational from sum_ed.
- rst (any time, including mid-DIV): every state register and every output goes to 0, and the block enters IDLE. in_ready, busy and done are 0 during and after reset.

## Timing
- Non-MRED:
  - one sample per cycle at full throughput
  - the last handshake at edge t gives done=1 in cycle t+1
  - busy falls in the same cycle that done rises
- in_ready is decoded from registered state only. There is no combinational path from in_valid.
- in_valid gaps are allowed and only stall the count.
- A sample counts only on a cycle where in_valid & in_ready are both high.
- MRED build, DIV timing:
  - A handshake with exact_sum≠0 and ED≠0 enters DIV.
  - DIV runs a restoring divider for exactly N+FRAC cycles, producing ED·2^FRAC / exact_sum as an (N+FRAC)-bit floor quotient.
  - The quotient is added to sum_rel on the last DIV cycle.
  - DIV then returns to RUN, or to DONE if the window is complete.
- MRED build, samples that skip DIV:
  - exact_sum==0: zero_count += 1, no division, stay in RUN.
  - ED==0 with exact_sum≠0: contributes 0, no division.
- Software computes MRED = sum_rel / 2^FRAC / (2^LOG2_SAMPLES − zero_count).

## Configuration
- ERR_METRIC_MRED_EN defined:
  - the DIV state, divider, zero_count and sum_rel are built
  - throughput is variable (stalls of N+FRAC cycles)
- Undefined:
  - no divider and no DIV state; zero_count and sum_rel are tied to 0
  - in_ready=1 throughout RUN

## Test plan
- LOG2_SAMPLES=2; 4 samples with approx=exact=0x1234 and in_valid continuous → err_count=0, sum_ed=0, max_ed=0, done exactly 1 cycle after the 4th handshake, then IDLE.
- LOG2_SAMPLES=2; 4 samples approx=0x0010, exact=0x0013, with a 3-cycle in_valid gap after sample 2 → err_count=4, sum_ed=12, max_ed=3, med_fx=0x300.
- Wrap/extreme: LOG2_SAMPLES=2; samples (0x0000,0xFFFF), (0xFFFF,0x0000), (5,5), (7,2) → ED 0xFFFF,0xFFFF,0,5; err_count=3, sum_ed=0x20003, max_ed=0xFFFF.
- Restart: pulse start after 2 of 4 samples → all counters read 0 the next cycle; done only after 4 further handshakes; start during DONE restarts cleanly.
- MRED (N=16, FRAC=16):
  - exact=100, approx=90 → in_ready low 32 cycles, sum_rel += 6553.
  - exact=0, approx=3 → zero_count=1, no stall.
  - approx=exact → no stall.
- Assert rst mid-DIV → same cycle: all outputs 0, in_ready=0, busy=0. After release the block stays in IDLE, with no done pulse until start.
